// File: rtl/mcu_word_framer_pkg.sv
// Shared constants for the MCU byte-link word framer: header bytes, FSM
// encodings and default frame geometry.
package mcu_word_framer_pkg;

    localparam logic [15:0] HDR_WORD        = 16'hC7E5;
    localparam logic [15:0] UPDATE_HDR_WORD = 16'hB79E;

    localparam logic [7:0] HDR_HI_DEF = HDR_WORD[15:8];
    localparam logic [7:0] HDR_LO_DEF = HDR_WORD[7:0];

    localparam int FRAME_WORDS_DEF = 2;
    localparam int TIMEOUT_CYC_DEF = 1000;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_WAIT_LO = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;

    // The decoder swaps the word back, so the first wire byte lands in the low half.
    function automatic logic [15:0] swap_bytes(input logic [7:0] first, input logic [7:0] second);
        return {second, first};
    endfunction

endpackage

// File: rtl/mcu_word_framer_gap.sv
// In-frame inter-byte gap timer: restarts on every byte, idles outside a frame,
// and flags expiry when the idle run reaches TIMEOUT_CYC cycles.
module gap_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] count;

    // NOTE: registers take non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst || clear || !enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 16'd1;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/mcu_word_framer.sv
// Receive-side byte-to-word framer: hunts for the two-byte header, then packs
// byte pairs into byte-swapped 16-bit words until the frame completes or stalls.
module mcu_word_framer
    import mcu_word_framer_pkg::*;
#(
    parameter int         FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [7:0] HDR_HI      = HDR_HI_DEF,
    parameter logic [7:0] HDR_LO      = HDR_LO_DEF
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [15:0] ok2,
    output logic        data_valid,
    output logic        locked,
    output logic        timeout_pulse,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS);

    logic [1:0] state;
    logic [7:0] prev_byte;
    logic       prev_ok;
    logic [7:0] lo_byte;
    logic [7:0] word_cnt;
    logic       in_frame;
    logic       expired;

    assign in_frame = (state != ST_HUNT);

    gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_in (clk_in),
        .rst    (rst),
        .clear  (byte_valid),
        .enable (in_frame),
        .expired(expired)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= ST_HUNT;
            prev_byte     <= '0;
            prev_ok       <= 1'b0;
            lo_byte       <= '0;
            word_cnt      <= '0;
            ok2           <= '0;
            data_valid    <= 1'b0;
            locked        <= 1'b0;
            timeout_pulse <= 1'b0;
            err_cnt       <= '0;
        end else begin
            data_valid    <= 1'b0;
            timeout_pulse <= 1'b0;

            if (expired) begin
                // Stalled frame: drop any half word and resume hunting from scratch.
                state         <= ST_HUNT;
                locked        <= 1'b0;
                prev_ok       <= 1'b0;
                timeout_pulse <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (byte_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (prev_ok && (prev_byte == HDR_HI) && (byte_in == HDR_LO)) begin
                            ok2        <= swap_bytes(HDR_HI, HDR_LO);
                            data_valid <= 1'b1;
                            word_cnt   <= 8'd1;
                            state      <= ST_WAIT_LO;
                            locked     <= 1'b1;
                            prev_ok    <= 1'b0;
                        end else begin
                            prev_byte <= byte_in;
                            prev_ok   <= 1'b1;
                        end
                    end
                    ST_WAIT_LO: begin
                        lo_byte <= byte_in;
                        state   <= ST_WAIT_HI;
                    end
                    ST_WAIT_HI: begin
                        ok2        <= swap_bytes(lo_byte, byte_in);
                        data_valid <= 1'b1;
                        word_cnt   <= word_cnt + 8'd1;
                        // Leaving on the last word lets the next header be seen immediately.
                        if ((word_cnt + 8'd1) == LAST_WORD) begin
                            state   <= ST_HUNT;
                            locked  <= 1'b0;
                            prev_ok <= 1'b0;
                        end else begin
                            state <= ST_WAIT_LO;
                        end
                    end
                    default: begin
                        state   <= ST_HUNT;
                        locked  <= 1'b0;
                        prev_ok <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcu_word_framer.sv
// Scoreboard bench for mcu_word_framer: a byte-stream reference model queues
// expected words and timeout counts; a monitor compares them as the DUT emits.
module tb_mcu_word_framer;

    localparam int T  = 8;
    localparam int FW = 2;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [15:0] ok2;
    logic        data_valid;
    logic        locked;
    logic        timeout_pulse;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] wq[$];
    logic [7:0]  tq[$];

    bit          m_in_frame;
    bit          m_hist_ok;
    bit          m_have_lo;
    logic [7:0]  m_hist;
    logic [7:0]  m_lo;
    int          m_words;
    int          m_err;
    int          idle_cnt;

    logic [15:0] last_ok2;
    bit          exp_locked;
    bit          mon_en;
    logic [15:0] exp_w;
    logic [7:0]  exp_e;

    mcu_word_framer #(
        .FRAME_WORDS(FW),
        .TIMEOUT_CYC(T),
        .HDR_HI     (8'hC7),
        .HDR_LO     (8'hE5)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .ok2          (ok2),
        .data_valid   (data_valid),
        .locked       (locked),
        .timeout_pulse(timeout_pulse),
        .err_cnt      (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: works on whole bytes and idle-run lengths, not cycles of an FSM.
    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_hist_ok  = 1'b0;
        m_have_lo  = 1'b0;
        m_hist     = '0;
        m_lo       = '0;
        m_words    = 0;
        m_err      = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_in_frame) begin
            if (m_hist_ok && m_hist == 8'hC7 && b == 8'hE5) begin
                wq.push_back({b, m_hist});
                m_in_frame = 1'b1;
                m_words    = 1;
                m_have_lo  = 1'b0;
            end else begin
                m_hist    = b;
                m_hist_ok = 1'b1;
            end
        end else if (!m_have_lo) begin
            m_lo      = b;
            m_have_lo = 1'b1;
        end else begin
            wq.push_back({b, m_lo});
            m_have_lo = 1'b0;
            m_words++;
            if (m_words == FW) begin
                m_in_frame = 1'b0;
                m_hist_ok  = 1'b0;
            end
        end
    endfunction

    function automatic void model_timeout();
        m_in_frame = 1'b0;
        m_have_lo  = 1'b0;
        m_hist_ok  = 1'b0;
        if (m_err < 255) m_err++;
        tq.push_back(8'(m_err));
    endfunction

    task automatic idle();
        idle_cnt++;
        if (m_in_frame && idle_cnt == T) model_timeout();
        byte_valid = 1'b0;
        @(posedge clk_in);
        #1;
        exp_locked = m_in_frame;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) idle();
        model_byte(b);
        idle_cnt   = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk_in);
        #1;
        byte_valid = 1'b0;
        exp_locked = m_in_frame;
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send(seq[i], 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        wq.delete();
        tq.delete();
        last_ok2   = '0;
        exp_locked = 1'b0;
        idle_cnt   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ok2"}, ok2, 16'h0000);
        check({tag, " data_valid"}, data_valid, 1'b0);
        check({tag, " locked"}, locked, 1'b0);
        check({tag, " timeout_pulse"}, timeout_pulse, 1'b0);
        check({tag, " err_cnt"}, err_cnt, 8'h00);
    endtask

    // Monitor: pops expectations only when the DUT presents a strobe or pulse.
    initial begin
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (data_valid === 1'b1) begin
                    if (wq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL strobe: unexpected ok2=%h, none expected", ok2);
                    end else begin
                        exp_w = wq.pop_front();
                        check("strobe ok2", ok2, exp_w);
                        last_ok2 = exp_w;
                    end
                end else begin
                    check("ok2 hold", ok2, last_ok2);
                end
                if (timeout_pulse === 1'b1) begin
                    if (tq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL timeout: unexpected pulse, err_cnt=%0d", err_cnt);
                    end else begin
                        exp_e = tq.pop_front();
                        check("timeout err_cnt", err_cnt, exp_e);
                    end
                end
                check("locked", locked, exp_locked);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         g;

        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = '0;
        mon_en     = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        last_ok2   = '0;
        exp_locked = 1'b0;
        idle_cnt   = 0;
        mon_en     = 1'b1;
        check_reset_outputs("reset");

        // Aligned header then one payload word, back to back.
        send_seq('{8'hC7, 8'hE5, 8'h05, 8'h03});
        repeat (2) idle();
        check("basic err_cnt", err_cnt, 8'h00);

        // Header found at an odd offset and after a repeated first header byte.
        send_seq('{8'h12, 8'hC7, 8'hC7, 8'hE5, 8'h05, 8'h01});
        repeat (2) idle();

        // A header pattern inside a frame is payload.
        send_seq('{8'hC7, 8'hE5, 8'hC7, 8'hE5, 8'h05, 8'h02, 8'hC7, 8'hE5, 8'h05, 8'h02});
        repeat (2) idle();

        // Stall after a half word.
        send_seq('{8'hC7, 8'hE5, 8'h05});
        repeat (T) idle();
        check("timeout err_cnt direct", err_cnt, 8'h01);
        check("timeout unlocks", locked, 1'b0);
        send_seq('{8'hC7, 8'hE5, 8'h05, 8'h03});
        repeat (2) idle();

        // Byte lands exactly in the expiry cycle.
        send_seq('{8'hC7, 8'hE5, 8'h05});
        send(8'h03, T - 1);
        repeat (2) idle();
        check("expiry-cycle byte err_cnt", err_cnt, 8'h01);

        // Reset in the middle of a word.
        send_seq('{8'hC7, 8'hE5, 8'h05});
        check("pre-reset strobes drained", wq.size(), 0);
        do_reset();
        check_reset_outputs("mid-frame reset");
        send(8'h03, 0);
        repeat (3) idle();
        check("post-reset stray byte locked", locked, 1'b0);
        send_seq('{8'hC7, 8'hE5});
        check("relock after reset", locked, 1'b1);
        send_seq('{8'h05, 8'h03});
        repeat (2) idle();

        // Saturation of the abort counter.
        for (int i = 0; i < 260; i++) begin
            send_seq('{8'hC7, 8'hE5, 8'h05});
            repeat (T + 1) idle();
        end
        check("err_cnt saturates", err_cnt, 8'hFF);

        // Randomised stream biased toward header bytes and near-expiry gaps.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            g = int'($urandom_range(0, 9));
            if (g < 3)      b = 8'hC7;
            else if (g < 6) b = 8'hE5;
            else            b = 8'($urandom_range(0, 255));
            g = int'($urandom_range(0, 9));
            if (g < 6)      g = 0;
            else if (g < 8) g = int'($urandom_range(1, 3));
            else            g = int'($urandom_range(T - 1, T + 1));
            send(b, g);
        end

        repeat (T + 4) idle();
        check("all strobes seen", wq.size(), 0);
        check("all timeouts seen", tq.size(), 0);
        check("final err_cnt", err_cnt, 8'(m_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
